// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic IDLE_BIT_DEF = 1'b0;

  // Enough bits to hold a length of 0..width inclusive.
  function automatic int len_w_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; o_msb is the bit currently at the top.
// Load has priority over shift; zeros fill from the bottom.
module piso_shift
  import seq_pattern_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_load_dat,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_load_dat;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends len bits of data MSB-first, repeat+1 passes back-to-back.
// All outputs registered except o_ready, which decodes the state.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int   WIDTH    = 16,
  parameter int   LEN_W    = len_w_of(WIDTH),
  parameter int   REP_W    = 4,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0] i_len,
  input  logic [REP_W-1:0] i_repeat,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_out,
  output logic             o_valid,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [LEN_W-1:0] r_len_m1;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [REP_W-1:0] r_pass_cnt;
  logic             r_out;
  logic             r_valid;
  logic             r_done;

  logic             w_len_ok;
  logic             w_accept;
  logic             w_step;
  logic             w_wrap;
  logic             w_load;
  logic [WIDTH-1:0] w_aligned;
  logic [WIDTH-1:0] w_load_dat;
  logic             w_sreg_msb;

  assign w_len_ok  = (i_len != '0) && (i_len <= LEN_MAX);
  assign w_accept  = (r_state == IDLE) && i_start && w_len_ok;
  // Left-justify so pattern bit len-1 lands on the register MSB.
  assign w_aligned = i_data << (LEN_MAX - i_len);

  assign w_step = (r_state == SHIFT) && !i_abort && (r_bit_cnt != '0);
  assign w_wrap = (r_state == SHIFT) && !i_abort && (r_bit_cnt == '0) && (r_pass_cnt != '0);

  // The shifter holds the bits still to come; the current bit already sits in r_out.
  assign w_load     = w_accept || w_wrap;
  assign w_load_dat = w_accept ? {w_aligned[WIDTH-2:0], 1'b0} : {r_pat[WIDTH-2:0], 1'b0};

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_shift   (w_step),
    .i_load_dat(w_load_dat),
    .o_msb     (w_sreg_msb)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_pat      <= '0;
      r_len_m1   <= '0;
      r_bit_cnt  <= '0;
      r_pass_cnt <= '0;
      r_out      <= IDLE_BIT;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_pat      <= w_aligned;
            r_len_m1   <= i_len - LEN_ONE;
            r_bit_cnt  <= i_len - LEN_ONE;
            r_pass_cnt <= i_repeat;
            r_out      <= w_aligned[WIDTH-1];
            r_valid    <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_abort) begin
            r_out   <= IDLE_BIT;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else if (r_bit_cnt != '0) begin
            r_bit_cnt <= r_bit_cnt - LEN_ONE;
            r_out     <= w_sreg_msb;
          end else if (r_pass_cnt != '0) begin
            r_bit_cnt  <= r_len_m1;
            r_pass_cnt <= r_pass_cnt - REP_ONE;
            r_out      <= r_pat[WIDTH-1];
          end else begin
            r_out   <= IDLE_BIT;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_out   <= IDLE_BIT;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_out   <= IDLE_BIT;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_out   = r_out;
  assign o_valid = r_valid;
  assign o_done  = r_done;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: accepts a parallel pattern word plus length and repeat count over a start/ready handshake. It drives the pattern MSB-first onto a single serial line, one bit per clock, and can repeat it back-to-back. It is the stimulus end of our serial sequence detectors. Its `out` feeds a detector's `in` directly, so overlapping and non-overlapping Mealy/Moore detectors can be exercised from parallel words instead of hand-written bit streams.

## Interface
- `WIDTH`, 16: maximum pattern length in bits (≥2).
- `LEN_W`, $clog2(WIDTH+1): width of `len`.
- `REP_W`, 4: width of `repeat`.
- `IDLE_BIT`, 1'b0: level driven on `out` when not transmitting.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only on a rising edge where `ready`=1.
- `data` in WIDTH: pattern; bit `len-1` is transmitted first, bit 0 last.
- `len` in LEN_W: pattern length, 1..WIDTH. Values 0 and >WIDTH are rejected.
- `repeat` in REP_W: extra repetitions; total passes = `repeat`+1.
- `abort` in 1: stop transmission immediately.
- `ready` out 1: high only in IDLE.
- `out` out 1: serial bit, registered.
- `valid` out 1: high while `out` carries a pattern bit.
- `done` out 1: one-cycle pulse after the last bit of the last pass.

## Operation
- States (in package): IDLE, SHIFT, DONE.
- Reset (`reset`=0, async): state=IDLE, `out`=IDLE_BIT, `valid`=0, `done`=0, `ready`=1, internal shift register, bit counter and pass counter cleared.
- **IDLE.** `ready`=1 and `out`=IDLE_BIT.
  - On an edge with `start`=1 and 1≤`len`≤WIDTH: capture `data`, `len` and `repeat`.
  - On the same edge: `out`<=data[len-1], `valid`<=1, bit counter<=len-1, pass counter<=repeat, go to SHIFT.
  - `start` with an illegal `len` is ignored; no state change and no `done`.
- **SHIFT.** Each edge drives the next lower bit.
  - When the bit counter reaches 0 and the pass counter is nonzero: reload the bit counter to len-1, decrement the pass counter, drive data[len-1] next.
  - Consecutive passes have no gap bit, so a detector sees the pattern concatenated.
  - When both counters are 0: `out`<=IDLE_BIT, `valid`<=0, `done`<=1, go to DONE.
- **DONE.** Lasts one cycle. `done`=1, `ready`=0, then IDLE with `done`<=0.
- **Abort.** `abort`=1 in SHIFT or DONE: next edge goes to IDLE with `out`=IDLE_BIT, `valid`=0, `done`=0. No `done` pulse is produced by an aborted transfer. `abort` in IDLE has no effect.
- **Precedence.** `abort` > normal progression. `start` while `ready`=0 is ignored and not queued.
- **Latched inputs.** `data`, `len` and `repeat` are sampled only at acceptance; later changes have no effect on the transfer in progress.
- **Width rules.**
  - Bit counter is LEN_W bits; pass counter is REP_W bits.
  - Maximum stream length is WIDTH·2^REP_W bits; no counter overflows.
  - `len`=1 is legal and sends one bit per pass.

## Timing
- Acceptance edge = edge 0. The first bit is valid from edge 0 until edge 1.
- Bit k (0-based, across all passes) is held from edge k to edge k+1.
- `valid` is high for exactly len·(repeat+1) cycles.
- `done` is high for the one cycle following the last bit, starting at edge len·(repeat+1).
- `ready` returns at edge len·(repeat+1)+1. Minimum spacing between accepted starts is len·(repeat+1)+1 cycles.
- All outputs are registered; there is no combinational input→output path, except that `ready` decodes state.
- Reset assertion mid-transfer forces reset values asynchronously. On deassertion the block is in IDLE and the interrupted pattern is lost.

## Structure
- Package `seq_pattern_pkg`:
  - `state_t` enum (IDLE, SHIFT, DONE).
  - IDLE_BIT default.
  - Function computing LEN_W from WIDTH.
- One natural sub-module, `piso_shift`: WIDTH-bit parallel-load, MSB-first shift register with load/shift enables and async active-low reset.
- The FSM and both counters stay in the top module.

## Test plan
- **Single pass.** data=16'h000D, len=4, repeat=0, start pulse → `out` = 1,1,0,1 over 4 cycles with `valid`=1. `done` pulse in cycle 5, `ready` high in cycle 6.
- **Overlap stream.** data=3'b110, len=3, repeat=2 → `out` = 110110110, 9 `valid` cycles, no gap bit, single `done`. Feed a 110 overlapping detector and check 3 detections.
- **Full width / minimum length.**
  - data=16'hA5F0, len=16, repeat=0 → 1010010111110000 MSB-first.
  - len=1, data=1, repeat=3 → 1,1,1,1.
- **Illegal and busy starts.**
  - len=0 start → `ready` stays 1, `valid` stays 0, no `done`.
  - len=17 start → same as len=0: ignored.
  - Second start during SHIFT → ignored; the first stream completes unchanged.
- **Abort.** Abort in the 3rd bit of a len=8 transfer → next edge `out`=IDLE_BIT, `valid`=0, `ready`=1, no `done`. The next start transmits correctly.
- **Reset.**
  - Async `reset`=0 mid-bit, between clock edges → outputs take reset values immediately.
  - After release, state is IDLE and a fresh transfer is correct.
